mdu_iterative: RTL and testbench

- Multi-cycle multiply/divide unit. Owns the architectural HI/LO registers for the MIPS datapath.
- Successor to the combinational mult/div ALU: parametrised width, registered HI/LO, start/busy/done handshake.
- Defined results for divide-by-zero and signed overflow.
- Sits beside the main ALU. The control unit stalls the pipeline on `busy`.

---
 rtl/mdu_iterative.sv | 193 +++++++++++++++++++
 tb/tb_mdu_iterative.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_MADD_EN to add MADD/MSUB (f=6/7) with an extra accumulate state.
module mdu_iterative #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       f,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
`ifdef MDU_MADD_EN
    S_FIX,
    S_ACC
`else
    S_FIX
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d;
  logic             mul_q, mul_d, negq_q, negq_d, negr_q, negr_d;
  logic             busy_d, done_d, dbz_d;
  logic [WIDTH-1:0] hi_d, lo_d;
`ifdef MDU_MADD_EN
  logic             mac_q, mac_d, sub_q, sub_d;
`endif

  // Request decode and operand magnitudes
  logic             accept, sgn_op, neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  always_comb begin
    accept = (f[3:2] == 2'b00);
`ifdef MDU_MADD_EN
    accept = accept | (f[3:1] == 3'b011);
`endif
    sgn_op = (f == 4'd0) || (f == 4'd2) || (f[3:1] == 3'b011);
    neg1   = sgn_op & op1[WIDTH-1];
    neg2   = sgn_op & op2[WIDTH-1];
    mag1   = neg1 ? -op1 : op1;
    mag2   = neg2 ? -op2 : op2;
  end

  // acc_hi holds partial product / remainder, acc_lo holds multiplier / quotient
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] prod;
  logic               pneg;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    mul_d    = mul_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    hi_d     = hi;
    lo_d     = lo;
    done_d   = 1'b0;
    dbz_d    = dbz;
`ifdef MDU_MADD_EN
    mac_d    = mac_q;
    sub_d    = sub_q;
    pneg     = negq_q ^ sub_q;
`else
    pneg     = negq_q;
`endif
    sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? b_q : '0)};
    trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, b_q};
    prod  = pneg ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

    unique case (state_q)
      S_IDLE: begin
        if (start && accept) begin
          mul_d    = f[1];
          negq_d   = neg1 ^ neg2;
          negr_d   = neg1;
          acc_hi_d = '0;
          acc_lo_d = f[1] ? mag2 : mag1;
          b_d      = f[1] ? mag1 : mag2;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = S_CALC;
`ifdef MDU_MADD_EN
          mac_d    = f[2];
          sub_d    = f[2] & f[0];
`endif
        end else if (start && f == 4'd4) begin
          hi_d   = op1;
          done_d = 1'b1;
        end else if (start && f == 4'd5) begin
          lo_d   = op1;
          done_d = 1'b1;
        end
      end
      S_CALC: begin
        if (mul_q) begin
          acc_hi_d = sum[WIDTH:1];
          acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        end else begin
          acc_hi_d = trial[WIDTH] ? {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]}
                                  : trial[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ~trial[WIDTH]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (mul_q) begin
`ifdef MDU_MADD_EN
          if (mac_q) begin
            {acc_hi_d, acc_lo_d} = prod;
            state_d = S_ACC;
            done_d  = 1'b0;
          end else begin
            {hi_d, lo_d} = prod;
          end
`else
          {hi_d, lo_d} = prod;
`endif
        end else begin
          // Divide by zero: magnitude remainder equals |op1|, so sign fix restores raw op1
          hi_d  = negr_q ? -acc_hi_q : acc_hi_q;
          lo_d  = (b_q == '0) ? '1 : (negq_q ? -acc_lo_q : acc_lo_q);
          dbz_d = (b_q == '0);
        end
      end
`ifdef MDU_MADD_EN
      S_ACC: begin
        {hi_d, lo_d} = {hi, lo} + {acc_hi_q, acc_lo_q};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      mul_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MDU_MADD_EN
      mac_q    <= 1'b0;
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
      mul_q    <= mul_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy     <= busy_d;
      done     <= done_d;
      dbz      <= dbz_d;
      hi       <= hi_d;
      lo       <= lo_d;
`ifdef MDU_MADD_EN
      mac_q    <= mac_d;
      sub_q    <= sub_d;
`endif
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed table, handshake corners, random vs model.
// MADD/MSUB checks are compiled in when MDU_MADD_EN is defined.
module tb_mdu_iterative;
  localparam int unsigned W   = 32;
  localparam int          LAT = W + 1;
`ifdef MDU_MADD_EN
  localparam int          NOPS = 8;
`else
  localparam int          NOPS = 6;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, busy, done, dbz;
  logic [3:0]   f;
  logic [W-1:0] op1, op2, hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_hi, m_lo;
  logic         m_dbz;

  mdu_iterative #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f(f), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Architectural reference: plain integer arithmetic on the whole HI/LO state
  task automatic model(input logic [3:0] fv, input logic [W-1:0] a, input logic [W-1:0] b);
    int                sa, sb;
    longint            ps;
    longint unsigned   pu;
    logic [2*W-1:0]    mm;
    sa = int'(a);
    sb = int'(b);
    ps = longint'(sa) * longint'(sb);
    pu = {32'h0, a} * {32'h0, b};
    case (fv)
      4'd0: begin
        if (b == '0) begin
          m_lo = '1; m_hi = a; m_dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = a; m_hi = '0; m_dbz = 1'b0;
        end else begin
          m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); m_dbz = 1'b0;
        end
      end
      4'd1: begin
        if (b == '0) begin
          m_lo = '1; m_hi = a; m_dbz = 1'b1;
        end else begin
          m_lo = a / b; m_hi = a % b; m_dbz = 1'b0;
        end
      end
      4'd2: {m_hi, m_lo} = 64'(ps);
      4'd3: {m_hi, m_lo} = 64'(pu);
      4'd4: m_hi = a;
      4'd5: m_lo = a;
`ifdef MDU_MADD_EN
      4'd6: begin mm = {m_hi, m_lo} + 64'(ps); {m_hi, m_lo} = mm; end
      4'd7: begin mm = {m_hi, m_lo} - 64'(ps); {m_hi, m_lo} = mm; end
`endif
      default: ;
    endcase
  endtask

  // Issue one request, wait (bounded) for done, check busy/latency/HI-LO stability
  task automatic do_op(input string nm, input logic [3:0] fv, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic [W-1:0] h0, l0;
    int  lat, exp_lat;
    bit  arith, moved;
    arith = (fv <= 4'd3);
`ifdef MDU_MADD_EN
    if (fv == 4'd6 || fv == 4'd7) arith = 1'b1;
`endif
    exp_lat = !arith ? 0 : ((fv >= 4'd6) ? LAT + 1 : LAT);
    h0 = hi;
    l0 = lo;
    @(negedge clk);
    start = 1'b1; f = fv; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0; f = 4'($urandom); op1 = $urandom; op2 = $urandom;
    chk({nm, " busy"}, 64'(busy), 64'(arith));
    lat = 0;
    moved = 1'b0;
    while (!done && lat < 3 * LAT) begin
      if (hi !== h0 || lo !== l0) moved = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    if (arith) chk({nm, " hilo stable"}, 64'(moved), 64'(0));
    model(fv, a, b);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    string        nm;
    logic [3:0]   fv;
    logic [W-1:0] a, b, eh, el;
    logic         edbz;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [W-1:0] h0, l0;
    int  lat;
    bit  moved;

    tbl[0]  = '{"multu max",   4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1]  = '{"mult -3*7",   4'd2, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[2]  = '{"div -7/2",    4'd0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3]  = '{"divu 100/7",  4'd1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    tbl[4]  = '{"divu by 0",   4'd1, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    tbl[5]  = '{"mult keeps dbz", 4'd2, 32'd5,      32'd6,         32'd0,         32'd30,        1'b1};
    tbl[6]  = '{"div overflow",4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    tbl[7]  = '{"mthi",        4'd4, 32'hA5A5_A5A5, 32'd0,         32'hA5A5_A5A5, 32'h8000_0000, 1'b0};
    tbl[8]  = '{"mtlo",        4'd5, 32'h1234_5678, 32'd9,         32'hA5A5_A5A5, 32'h1234_5678, 1'b0};
    tbl[9]  = '{"div 7/-2",    4'd0, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    tbl[10] = '{"div min/0",   4'd0, 32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
    tbl[11] = '{"div -8/0",    4'd0, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};

    rst_n = 1'b0; start = 1'b0; f = '0; op1 = '0; op2 = '0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    #12;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset dbz",  64'(dbz),  64'(0));
    chk("reset hi",   64'(hi),   64'(0));
    chk("reset lo",   64'(lo),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Consecutive table entries issue in the done cycle of the previous one
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].nm, tbl[i].fv, tbl[i].a, tbl[i].b);
      chk({tbl[i].nm, " hi"},  64'(hi),  64'(tbl[i].eh));
      chk({tbl[i].nm, " lo"},  64'(lo),  64'(tbl[i].el));
      chk({tbl[i].nm, " dbz"}, 64'(dbz), 64'(tbl[i].edbz));
    end

    // start held through busy with a different request; then accepted in the done cycle
    h0 = hi; l0 = lo;
    @(negedge clk);
    start = 1'b1; f = 4'd1; op1 = 32'd1000; op2 = 32'd9;
    @(posedge clk); #1;
    f = 4'd4; op1 = 32'hDEAD_BEEF; op2 = 32'd3;
    lat = 0; moved = 1'b0;
    while (!done && lat < 3 * LAT) begin
      if (hi !== h0 || lo !== l0) moved = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("held latency", 64'(lat), 64'(LAT));
    chk("held hilo stable", 64'(moved), 64'(0));
    chk("held lo", 64'(lo), 64'(111));
    chk("held hi", 64'(hi), 64'(1));
    chk("held dbz", 64'(dbz), 64'(0));
    model(4'd1, 32'd1000, 32'd9);
    @(posedge clk); #1;
    chk("b2b mthi done", 64'(done), 64'(1));
    chk("b2b mthi busy", 64'(busy), 64'(0));
    chk("b2b mthi hi",   64'(hi),   64'(32'hDEAD_BEEF));
    chk("b2b mthi lo",   64'(lo),   64'(111));
    model(4'd4, 32'hDEAD_BEEF, 32'd3);
    @(negedge clk);
    start = 1'b0;

    // Unsupported function codes are ignored
    @(negedge clk);
    start = 1'b1; f = 4'd9; op1 = 32'h5555_5555; op2 = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("nop9 done", 64'(done), 64'(0));
    chk("nop9 busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("nop9 hi", 64'(hi), 64'(m_hi));
`ifndef MDU_MADD_EN
    @(negedge clk);
    start = 1'b1; f = 4'd6; op1 = 32'd3; op2 = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("nop6 done", 64'(done), 64'(0));
    chk("nop6 busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("nop6 lo", 64'(lo), 64'(m_lo));
`endif

`ifdef MDU_MADD_EN
    do_op("mthi 0", 4'd4, 32'd0, 32'd0);
    do_op("mtlo 10", 4'd5, 32'd10, 32'd0);
    do_op("madd 3*4", 4'd6, 32'd3, 32'd4);
    chk("madd hi", 64'(hi), 64'(0));
    chk("madd lo", 64'(lo), 64'(22));
    do_op("msub 5*5", 4'd7, 32'd5, 32'd5);
    chk("msub hi", 64'(hi), 64'(32'hFFFF_FFFF));
    chk("msub lo", 64'(lo), 64'(32'hFFFF_FFFD));
`endif

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; f = 4'd2; op1 = 32'd12345; op2 = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 64'(busy), 64'(0));
    chk("midreset done", 64'(done), 64'(0));
    chk("midreset hi",   64'(hi),   64'(0));
    chk("midreset lo",   64'(lo),   64'(0));
    chk("midreset dbz",  64'(dbz),  64'(0));
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post reset multu", 4'd3, 32'd6, 32'd7);
    chk("post reset hi", 64'(hi), 64'(0));
    chk("post reset lo", 64'(lo), 64'(42));

    // Random requests against the reference model, with optional idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   fv;
      logic [W-1:0] a, b;
      fv = 4'($urandom_range(0, NOPS - 1));
      a  = pick();
      b  = pick();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      do_op("rand", fv, a, b);
      chk("rand hi",  64'(hi),  64'(m_hi));
      chk("rand lo",  64'(lo),  64'(m_lo));
      chk("rand dbz", 64'(dbz), 64'(m_dbz));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
